uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Command controller that sits between the osdvu `uart` instance and the pulse-generation datapath. It parses framed 5-byte commands from the UART receive stream and writes or reads a bank of four 16-bit configuration registers. It answers every complete frame over the UART transmit side, sequencing the `transmit`/`is_transmitting` handshake. It replaces ad-hoc `received`-driven register loads at the top level.

## Interface
- `SYNC` — default 8'hAA — frame start byte.
- `TIMEOUT` — default 1200000 — maximum inter-byte gap in clk cycles inside a frame (100 ms at 12 MHz); minimum legal value 2.
- `clk` — in, 1 — system clock; all logic is on the rising edge.
- `rst_n` — in, 1 — asynchronous, active-low reset.
- `received` — in, 1 — one-cycle strobe from the uart; `rx_byte` is valid in the same cycle.
- `rx_byte` — in, 8 — received byte.
- `recv_error` — in, 1 — uart framing error strobe.
- `is_transmitting` — in, 1 — uart transmitter busy.
- `transmit` — out, 1 — one-cycle request to send `tx_byte`.
- `tx_byte` — out, 8 — byte to send; held stable from the `transmit` cycle until the byte completes.
- `cfg_period`, `cfg_width`, `cfg_delay`, `cfg_ctrl` — out, 16 each — configuration registers at addresses 0–3.
- `cfg_update` — out, 1 — one-cycle pulse, high in the cycle in which any cfg register changes.
- `busy` — out, 1 — high from SYNC acceptance until the last response byte has completed.

## Operation
- **Frame format:** SYNC, ADDR, DHI, DLO, CSUM. The frame is valid when CSUM == ADDR ^ DHI ^ DLO.
  - `ADDR[7]` = 1 selects a read; 0 selects a write.
  - `ADDR[6:0]` must be 0–3; any other value is a bad address.
- **Parser states:** IDLE → ADDR → DHI → DLO → CSUM → EXEC → TX_LOAD → TX_WAIT → (TX_LOAD for the next byte, or IDLE).
- **IDLE:** any byte other than SYNC is discarded. SYNC moves to ADDR and sets `busy`.
- **ADDR, DHI, DLO, CSUM:** each `received` strobe captures the byte and advances one state.
- **EXEC:**
  - Bad checksum or bad address: response is NAK 8'h15. No register changes.
  - Valid write: the register is loaded with {DHI,DLO} and `cfg_update` pulses. Response is ACK 8'h06.
  - Valid read: response is three bytes: 8'h06, reg[15:8], reg[7:0]. A read never pulses `cfg_update`.
- **TX_LOAD:** waits until `is_transmitting` = 0, then asserts `transmit` for one cycle with `tx_byte` set.
- **TX_WAIT:** waits for `is_transmitting` to rise, then to fall. It then moves to TX_LOAD if response bytes remain, otherwise to IDLE with `busy` cleared.
- **Inter-byte timeout:** a gap counter resets on every `received` strobe while in ADDR..CSUM. Reaching TIMEOUT−1 forces IDLE and clears `busy`. No response is sent.
- **Receive error:** `recv_error` in ADDR..CSUM forces IDLE silently. In IDLE it is ignored.
- **Bytes arriving in EXEC, TX_LOAD or TX_WAIT** are discarded. The parser does not resync mid-response; the next frame must begin after `busy` falls.
- **Simultaneous `received` and `recv_error`:** the error wins and the byte is dropped.
- **Reset:** all cfg registers = 16'h0000, `cfg_update` = 0, `transmit` = 0, `tx_byte` = 8'h00, `busy` = 0, state = IDLE, gap counter = 0. Asserting reset mid-frame or mid-response aborts immediately. A uart byte already in flight completes on its own.

## Timing
- All outputs are registered.
- CSUM byte sampled at edge E:
  - EXEC occupies cycle E→E+1.
  - cfg register and `cfg_update` are visible after edge E+1, `cfg_update` for exactly one cycle.
  - Earliest `transmit` is after edge E+2.
- **`transmit` rules:**
  - High for exactly one cycle per response byte.
  - Never asserted while `is_transmitting` = 1.
  - Never re-asserted before the previous byte's `is_transmitting` fall has been seen.
- **Timeout:** last byte at edge B; with no further byte, state = IDLE after edge B+TIMEOUT−1.
- **Throughput:** one frame per 5 received bytes plus 1 or 3 response bytes. No command queueing.

## Test plan
- **Write:** AA 02 12 34 24 → `cfg_delay` = 16'h1234, one `cfg_update` pulse, single transmit of 8'h06, `busy` low after the byte completes.
- **Read:** after the write above, AA 82 00 00 82 → transmits 06, 12, 34 in order with no overlap of `is_transmitting`; `cfg_update` stays 0.
- **Bad checksum / bad address:** AA 01 00 05 00 → NAK 8'h15, `cfg_width` unchanged. AA 05 00 00 05 → NAK 8'h15, no register change.
- **Noise and timeout:** bytes 00 FF 55 in IDLE → no response. AA 00 then a gap of TIMEOUT cycles → IDLE, no transmit. A following AA 00 00 07 07 → `cfg_period` = 16'h0007, ACK.
- **recv_error:** strobe after AA 03 → silent abort. A subsequent valid frame AA 03 AB CD 65 → `cfg_ctrl` = 16'hABCD, ACK.
- **Reset mid-response:** drop `rst_n` during read response byte 2 → `transmit` = 0, `busy` = 0, all cfg = 0, no further bytes requested after release.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Framed UART command parser: SYNC, ADDR, DHI, DLO, CSUM -> write/read one of
// four 16-bit config registers, answering each complete frame over UART TX.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC    = 8'hAA,
  parameter int         TIMEOUT = 1200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error,
  input  logic        is_transmitting,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  output logic [15:0] cfg_period,
  output logic [15:0] cfg_width,
  output logic [15:0] cfg_delay,
  output logic [15:0] cfg_ctrl,
  output logic        cfg_update,
  output logic        busy
);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam int         GW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Gap value seen at the edge where the counter would reach TIMEOUT-1
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DHI, S_DLO, S_CSUM, S_EXEC, S_TX_LOAD, S_TX_WAIT
  } state_t;

  state_t          state;
  logic [GW-1:0]   gap;
  logic [7:0]      addr, dhi, dlo, csum;
  logic [15:0]     cfg [4];
  logic [7:0]      resp [3];
  logic [1:0]      resp_last, resp_idx;
  logic            seen_rise;
  logic            frame_ok;

  assign frame_ok   = (csum == (addr ^ dhi ^ dlo)) && (addr[6:2] == 5'd0);
  assign cfg_period = cfg[0];
  assign cfg_width  = cfg[1];
  assign cfg_delay  = cfg[2];
  assign cfg_ctrl   = cfg[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      gap        <= '0;
      addr       <= '0;
      dhi        <= '0;
      dlo        <= '0;
      csum       <= '0;
      for (int i = 0; i < 4; i++) cfg[i] <= '0;
      for (int i = 0; i < 3; i++) resp[i] <= '0;
      resp_last  <= '0;
      resp_idx   <= '0;
      seen_rise  <= 1'b0;
      transmit   <= 1'b0;
      tx_byte    <= '0;
      cfg_update <= 1'b0;
      busy       <= 1'b0;
    end else begin
      transmit   <= 1'b0;
      cfg_update <= 1'b0;
      case (state)
        S_IDLE: begin
          gap <= '0;
          if (received && !recv_error && rx_byte == SYNC) begin
            state <= S_ADDR;
            busy  <= 1'b1;
          end
        end
        S_ADDR, S_DHI, S_DLO, S_CSUM: begin
          // Error beats a same-cycle byte; timeout aborts silently
          if (recv_error || (!received && gap == GAP_LAST)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            gap   <= '0;
          end else if (received) begin
            gap <= '0;
            case (state)
              S_ADDR:  begin addr <= rx_byte; state <= S_DHI;  end
              S_DHI:   begin dhi  <= rx_byte; state <= S_DLO;  end
              S_DLO:   begin dlo  <= rx_byte; state <= S_CSUM; end
              default: begin csum <= rx_byte; state <= S_EXEC; end
            endcase
          end else begin
            gap <= gap + 1'b1;
          end
        end
        S_EXEC: begin
          resp_idx <= '0;
          state    <= S_TX_LOAD;
          if (!frame_ok) begin
            resp[0]   <= NAK;
            resp_last <= 2'd0;
          end else if (addr[7]) begin
            resp[0]   <= ACK;
            resp[1]   <= cfg[addr[1:0]][15:8];
            resp[2]   <= cfg[addr[1:0]][7:0];
            resp_last <= 2'd2;
          end else begin
            cfg[addr[1:0]] <= {dhi, dlo};
            cfg_update     <= 1'b1;
            resp[0]        <= ACK;
            resp_last      <= 2'd0;
          end
        end
        S_TX_LOAD: begin
          if (!is_transmitting) begin
            transmit  <= 1'b1;
            tx_byte   <= resp[resp_idx];
            seen_rise <= 1'b0;
            state     <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          // Next byte only after the busy flag has both risen and fallen
          if (is_transmitting) begin
            seen_rise <= 1'b1;
          end else if (seen_rise) begin
            if (resp_idx == resp_last) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              resp_idx <= resp_idx + 1'b1;
              state    <= S_TX_LOAD;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame table plus timing, timeout, error
// and reset sequences against a simple uart transmitter model.
module tb_uart_cmd_ctrl;
  localparam int TIMEOUT = 16;
  localparam int TXLEN   = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        received, recv_error;
  logic [7:0]  rx_byte;
  logic        is_transmitting = 1'b0;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic [15:0] cfg_period, cfg_width, cfg_delay, cfg_ctrl;
  logic        cfg_update, busy;

  int          vectors = 0, miscompares = 0;
  int          bcnt = 0, ovl = 0, upd_cnt = 0;
  logic [7:0]  txq [$];

  uart_cmd_ctrl #(.SYNC(8'hAA), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .received(received), .rx_byte(rx_byte),
    .recv_error(recv_error), .is_transmitting(is_transmitting),
    .transmit(transmit), .tx_byte(tx_byte), .cfg_period(cfg_period),
    .cfg_width(cfg_width), .cfg_delay(cfg_delay), .cfg_ctrl(cfg_ctrl),
    .cfg_update(cfg_update), .busy(busy)
  );

  always #5 clk = ~clk;

  // uart transmitter model; not reset so an in-flight byte finishes
  always @(posedge clk) begin
    if (transmit) begin
      if (is_transmitting) ovl <= ovl + 1;
      txq.push_back(tx_byte);
      bcnt            <= TXLEN;
      is_transmitting <= 1'b1;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) is_transmitting <= 1'b0;
    end
    if (cfg_update) upd_cnt <= upd_cnt + 1;
  end

  typedef struct {
    logic [39:0] frame;
    int          nresp;
    logic [23:0] resp;
    logic [63:0] cfg;   // {ctrl, delay, width, period}
    int          upd;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    received = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    received = 1'b0;
  endtask

  task automatic run_frame(input logic [39:0] f);
    logic [39:0] t;
    t = f;
    for (int k = 0; k < 5; k++) begin
      send_byte(t[39-8*k -: 8]);
      if (k < 4) repeat (2) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " idle"}, {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [63:0] cfg_all();
    return {cfg_ctrl, cfg_delay, cfg_width, cfg_period};
  endfunction

  initial begin
    int base, u0;
    logic [23:0] r;
    vt[0] = '{40'hAA_02_12_34_24, 1, 24'h06_00_00, 64'h0000_1234_0000_0000, 1};
    vt[1] = '{40'hAA_82_00_00_82, 3, 24'h06_12_34, 64'h0000_1234_0000_0000, 0};
    vt[2] = '{40'hAA_01_00_05_00, 1, 24'h15_00_00, 64'h0000_1234_0000_0000, 0};
    vt[3] = '{40'hAA_05_00_00_05, 1, 24'h15_00_00, 64'h0000_1234_0000_0000, 0};
    vt[4] = '{40'hAA_03_5A_5A_03, 1, 24'h06_00_00, 64'h5A5A_1234_0000_0000, 1};
    vt[5] = '{40'hAA_01_00_05_04, 1, 24'h06_00_00, 64'h5A5A_1234_0005_0000, 1};
    vt[6] = '{40'hAA_83_00_00_83, 3, 24'h06_5A_5A, 64'h5A5A_1234_0005_0000, 0};
    vt[7] = '{40'hAA_85_00_00_85, 1, 24'h15_00_00, 64'h5A5A_1234_0005_0000, 0};

    rst_n = 1'b0; received = 1'b0; recv_error = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst transmit", {63'd0, transmit}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst tx_byte", {56'd0, tx_byte}, 64'd0);
    chk("rst cfg_update", {63'd0, cfg_update}, 64'd0);
    chk("rst cfg", cfg_all(), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      base = txq.size();
      u0   = upd_cnt;
      run_frame(vt[v].frame);
      wait_idle($sformatf("vec%0d", v));
      chk($sformatf("vec%0d nresp", v), 64'(txq.size() - base), 64'(vt[v].nresp));
      r = vt[v].resp;
      for (int k = 0; k < vt[v].nresp && base + k < txq.size(); k++)
        chk($sformatf("vec%0d byte%0d", v, k), {56'd0, txq[base+k]}, {56'd0, r[23-8*k -: 8]});
      chk($sformatf("vec%0d cfg", v), cfg_all(), vt[v].cfg);
      chk($sformatf("vec%0d upd", v), 64'(upd_cnt - u0), 64'(vt[v].upd));
    end

    // Noise in IDLE: no response, not busy
    base = txq.size();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h55);
    repeat (20) @(negedge clk);
    chk("noise busy", {63'd0, busy}, 64'd0);
    chk("noise tx", 64'(txq.size() - base), 64'd0);

    // Timeout: idle after edge B+TIMEOUT-1, not before
    send_byte(8'hAA); repeat (2) @(negedge clk);
    send_byte(8'h00);
    repeat (TIMEOUT - 2) @(negedge clk);
    chk("timeout early busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("timeout busy", {63'd0, busy}, 64'd0);
    repeat (10) @(negedge clk);
    chk("timeout tx", 64'(txq.size() - base), 64'd0);
    run_frame(40'hAA_00_00_07_07);
    wait_idle("after timeout");
    chk("after timeout ack", {56'd0, txq[txq.size()-1]}, 64'h06);
    chk("after timeout cfg", cfg_all(), 64'h5A5A_1234_0005_0007);

    // recv_error aborts silently, also when coincident with a byte
    base = txq.size();
    send_byte(8'hAA); repeat (2) @(negedge clk);
    send_byte(8'h03);
    @(negedge clk); recv_error = 1'b1;
    @(negedge clk); recv_error = 1'b0;
    chk("rxerr busy", {63'd0, busy}, 64'd0);
    send_byte(8'hAA);
    @(negedge clk); received = 1'b1; recv_error = 1'b1; rx_byte = 8'h03;
    @(negedge clk); received = 1'b0; recv_error = 1'b0;
    chk("rxerr coincident busy", {63'd0, busy}, 64'd0);
    repeat (20) @(negedge clk);
    chk("rxerr tx", 64'(txq.size() - base), 64'd0);
    run_frame(40'hAA_03_AB_CD_65);
    wait_idle("after rxerr");
    chk("after rxerr ack", {56'd0, txq[txq.size()-1]}, 64'h06);
    chk("after rxerr cfg", cfg_all(), 64'hABCD_1234_0005_0007);

    // Write latency: cfg/cfg_update after E+1, transmit after E+2
    send_byte(8'hAA); repeat (2) @(negedge clk);
    send_byte(8'h02); repeat (2) @(negedge clk);
    send_byte(8'h55); repeat (2) @(negedge clk);
    send_byte(8'hAA); repeat (2) @(negedge clk);
    send_byte(8'hFD);
    chk("E upd", {63'd0, cfg_update}, 64'd0);
    chk("E busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("E+1 upd", {63'd0, cfg_update}, 64'd1);
    chk("E+1 delay", {48'd0, cfg_delay}, 64'h55AA);
    chk("E+1 transmit", {63'd0, transmit}, 64'd0);
    @(negedge clk);
    chk("E+2 upd", {63'd0, cfg_update}, 64'd0);
    chk("E+2 transmit", {63'd0, transmit}, 64'd1);
    chk("E+2 tx_byte", {56'd0, tx_byte}, 64'h06);
    wait_idle("latency");

    // Reset during second response byte of a read
    base = txq.size();
    run_frame(40'hAA_82_00_00_82);
    for (int n = 0; n < 500 && txq.size() < base + 2; n++) @(negedge clk);
    chk("reset reached byte2", 64'(txq.size() - base), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("reset transmit", {63'd0, transmit}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset cfg", cfg_all(), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("reset no more tx", 64'(txq.size() - base), 64'd2);
    chk("reset busy after", {63'd0, busy}, 64'd0);
    chk("tx overlap", 64'(ovl), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
